// File: rtl/nf_10g_tx_arb_pkg.sv
// rtl/nf_10g_tx_arb_pkg.sv - shared state encoding, counter width and index-width helper for the 10G TX arbiter
package nf_10g_tx_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  localparam int PKT_CNT_W = 32;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nf_rr_pick.sv
// rtl/nf_rr_pick.sv - combinational round-robin picker: first requester after last_grant, wrapping
module nf_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  logic [N-1:0] shifted;
  int           idx;

  // Walk from the farthest candidate to the nearest so the nearest requester is written last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    shifted = '0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx     = (int'(last_grant) + k) % N;
      shifted = req >> idx;
      if (shifted[0]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/nf_10g_tx_arbiter.sv
// rtl/nf_10g_tx_arbiter.sv - packet-granular round-robin AXI-Stream arbiter toward 10G TX
// Define NF_TX_ARB_PKT_CNT_EN to add per-port forwarded-packet counters with pkt_cnt_clear.
module nf_10g_tx_arbiter
  import nf_10g_tx_arb_pkg::*;
#(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  localparam int KW = C_AXIS_DATA_WIDTH / 8,
  localparam int IW = idx_width(C_NUM_PORTS)
) (
  input  logic                                        core_clk,
  input  logic                                        rst,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_PORTS*KW-1:0]                   s_axis_tkeep,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [KW-1:0]                               m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
`ifdef NF_TX_ARB_PKT_CNT_EN
  input  logic                                        pkt_cnt_clear,
  output logic [C_NUM_PORTS*PKT_CNT_W-1:0]            pkt_cnt,
`endif
  output logic [IW-1:0]                               grant_idx,
  output logic                                        grant_active
);

  logic [0:0]             state_q;
  logic [IW-1:0]          grant_q;
  logic [IW-1:0]          last_grant_q;
  logic [IW-1:0]          winner;
  logic                   any_req;
  logic [C_NUM_PORTS-1:0] grant_oh;
  logic                   in_pkt;
  logic                   g_valid;
  logic                   g_last;
  logic                   eop;

  nf_rr_pick #(
    .N  (C_NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign in_pkt   = (state_q == ST_PKT);
  assign grant_oh = C_NUM_PORTS'(1) << grant_q;
  assign g_valid  = |(s_axis_tvalid & grant_oh);
  assign g_last   = |(s_axis_tlast & grant_oh);
  assign eop      = in_pkt & g_valid & g_last & m_axis_tready;

  // last_grant resets to the top port so port 0 has first priority.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(C_NUM_PORTS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= ST_PKT;
          end
        end
        default: begin
          if (eop) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Payload is muxed unconditionally; only valid/last/ready are qualified by the grant.
  assign m_axis_tdata  = C_AXIS_DATA_WIDTH'(s_axis_tdata >> (C_AXIS_DATA_WIDTH * int'(grant_q)));
  assign m_axis_tkeep  = KW'(s_axis_tkeep >> (KW * int'(grant_q)));
  assign m_axis_tuser  = C_AXIS_TUSER_WIDTH'(s_axis_tuser >> (C_AXIS_TUSER_WIDTH * int'(grant_q)));
  assign m_axis_tvalid = in_pkt & g_valid;
  assign m_axis_tlast  = in_pkt & g_last;
  assign s_axis_tready = (in_pkt & m_axis_tready) ? grant_oh : '0;
  assign grant_idx     = grant_q;
  assign grant_active  = in_pkt;

`ifdef NF_TX_ARB_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] cnt_q [C_NUM_PORTS];

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (pkt_cnt_clear) begin
          cnt_q[i] <= '0;
        end else if (s_axis_tready[i] & s_axis_tvalid[i] & s_axis_tlast[i]) begin
          cnt_q[i] <= cnt_q[i] + PKT_CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[g*PKT_CNT_W +: PKT_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_nf_10g_tx_arbiter.sv
// tb/tb_nf_10g_tx_arbiter.sv - self-checking bench for nf_10g_tx_arbiter with a packet-level reference model
module tb_nf_10g_tx_arbiter;
  import nf_10g_tx_arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 8;
  localparam int IW = 2;

  logic                 core_clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NP*DW-1:0]     s_axis_tdata = '0;
  logic [NP*KW-1:0]     s_axis_tkeep = '0;
  logic [NP*UW-1:0]     s_axis_tuser = '0;
  logic [NP-1:0]        s_axis_tvalid = '0;
  logic [NP-1:0]        s_axis_tlast = '0;
  logic [NP-1:0]        s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic [UW-1:0]        m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready = 1'b1;
  logic [IW-1:0]        grant_idx;
  logic                 grant_active;
`ifdef NF_TX_ARB_PKT_CNT_EN
  logic                 pkt_cnt_clear = 1'b0;
  logic [NP*32-1:0]     pkt_cnt;
`endif

  nf_10g_tx_arbiter #(
    .C_NUM_PORTS        (NP),
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .core_clk      (core_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
`ifdef NF_TX_ARB_PKT_CNT_EN
    .pkt_cnt_clear (pkt_cnt_clear),
    .pkt_cnt       (pkt_cnt),
`endif
    .grant_idx     (grant_idx),
    .grant_active  (grant_active)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    int            gap;
  } beat_t;

  beat_t q[NP][$];
  int    gap_cnt[NP];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  int    log_port[$];
  int    log_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: one packet owner at a time, round robin from the previous owner, bubble after each packet.
  logic mdl_busy;
  int   mdl_owner;
  int   mdl_last;

  function automatic int rr(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (v[(last + k) % NP]) return (last + k) % NP;
    end
    return 0;
  endfunction

  always @(posedge core_clk or posedge rst) begin
    if (rst) begin
      mdl_busy  <= 1'b0;
      mdl_owner <= 0;
      mdl_last  <= NP - 1;
    end else if (!mdl_busy) begin
      if (|s_axis_tvalid) begin
        mdl_busy  <= 1'b1;
        mdl_owner <= rr(s_axis_tvalid, mdl_last);
      end
    end else if (s_axis_tvalid[mdl_owner] && s_axis_tlast[mdl_owner] && m_axis_tready) begin
      mdl_busy <= 1'b0;
      mdl_last <= mdl_owner;
    end
  end

  always @(negedge core_clk) begin
    logic [NP-1:0] exp_rdy;
    logic          exp_v;
    exp_v   = mdl_busy && s_axis_tvalid[mdl_owner];
    exp_rdy = '0;
    if (mdl_busy && m_axis_tready) exp_rdy[mdl_owner] = 1'b1;
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
    chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
    chk("grant_active", 64'(grant_active), 64'(mdl_busy));
    if (mdl_busy) chk("grant_idx", 64'(grant_idx), 64'(mdl_owner));
    if (exp_v) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(s_axis_tdata[mdl_owner*DW +: DW]));
      chk("m_tkeep", 64'(m_axis_tkeep), 64'(s_axis_tkeep[mdl_owner*KW +: KW]));
      chk("m_tuser", 64'(m_axis_tuser), 64'(s_axis_tuser[mdl_owner*UW +: UW]));
      chk("m_tlast", 64'(m_axis_tlast), 64'(s_axis_tlast[mdl_owner]));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_cnt++;
      if (m_axis_tlast) begin
        log_port.push_back(int'(m_axis_tdata[31:24]));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0 && gap_cnt[i] == 0) begin
        s_axis_tvalid[i]            = 1'b1;
        s_axis_tlast[i]             = q[i][0].l;
        s_axis_tdata[i*DW +: DW]    = q[i][0].d;
        s_axis_tkeep[i*KW +: KW]    = q[i][0].k;
        s_axis_tuser[i*UW +: UW]    = q[i][0].u;
      end else begin
        s_axis_tvalid[i]            = 1'b0;
        s_axis_tlast[i]             = 1'b0;
        s_axis_tdata[i*DW +: DW]    = 32'hDEAD_0000 | DW'(i);
        s_axis_tkeep[i*KW +: KW]    = '0;
        s_axis_tuser[i*UW +: UW]    = '0;
      end
    end
  endtask

  task automatic tick();
    logic [NP-1:0] acc;
    drive();
    @(negedge core_clk);
    acc = s_axis_tvalid & s_axis_tready;
    @(posedge core_clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        q[i].delete(0);
        if (q[i].size() > 0) gap_cnt[i] = q[i][0].gap;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    drive();
  endtask

  task automatic push(input int p, input int id, input int nb, input int gap_at, input int gap_len);
    beat_t bt;
    for (int b = 0; b < nb; b++) begin
      bt.d   = {8'(p), 8'(id), 16'(b)};
      bt.k   = (b == 1) ? KW'(0) : KW'(4'hF);
      bt.u   = UW'(id * 16 + b);
      bt.l   = (b == nb - 1);
      bt.gap = (b == gap_at) ? gap_len : 0;
      if (q[p].size() == 0) gap_cnt[p] = bt.gap;
      q[p].push_back(bt);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NP; i++) begin
      q[i].delete();
      gap_cnt[i] = 0;
    end
  endtask

  task automatic clear_log();
    log_port.delete();
    log_cyc.delete();
    beat_cnt = 0;
  endtask

  function automatic logic all_empty();
    for (int i = 0; i < NP; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int lp(input int i);
    return (i < log_port.size()) ? log_port[i] : -1;
  endfunction

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1000;
  endfunction

  task automatic run_idle(input string nm, input int max);
    int n;
    n = 0;
    while (n < max && !(all_empty() && !mdl_busy)) begin
      tick();
      n++;
    end
    chk({nm, "_done_in_budget"}, 64'(n < max), 64'(1));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    flush();
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    int n;
    flush();
    m_axis_tready = 1'b1;
    tick();
    chk("rst_grant_idx", 64'(grant_idx), 64'(0));
    chk("rst_grant_active", 64'(grant_active), 64'(0));
    chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));

    // Ports 0 and 2 with 3-beat packets: port 0 first, bubble, then port 2.
    do_reset();
    push(0, 1, 3, -1, 0);
    push(2, 2, 3, -1, 0);
    run_idle("t1", 40);
    chk("t1_pkts", 64'(log_port.size()), 64'(2));
    chk("t1_first", 64'(lp(0)), 64'(0));
    chk("t1_second", 64'(lp(1)), 64'(2));
    chk("t1_eop_spacing", 64'(lc(1) - lc(0)), 64'(4));

    // All ports continuously valid with single-beat packets.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push(p, 10 + r, 1, -1, 0);
    run_idle("t2", 40);
    chk("t2_pkts", 64'(log_port.size()), 64'(8));
    for (int i = 0; i < 5; i++) chk("t2_order", 64'(lp(i)), 64'(i % NP));
    chk("t2_spacing_a", 64'(lc(1) - lc(0)), 64'(2));
    chk("t2_spacing_b", 64'(lc(4) - lc(3)), 64'(2));

    // Downstream stall mid-packet on port 1 while port 0 waits.
    do_reset();
    push(1, 7, 3, -1, 0);
    n = 0;
    while (q[1].size() > 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t3_first_beat", 64'(n < 20), 64'(1));
    push(0, 8, 1, -1, 0);
    m_axis_tready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      drive();
      #1;
      chk("t3_stall_grant", 64'(grant_idx), 64'(1));
      chk("t3_stall_tready", 64'(s_axis_tready), 64'(0));
      chk("t3_stall_tdata", 64'(m_axis_tdata), 64'(32'h0107_0001));
      tick();
    end
    m_axis_tready = 1'b1;
    run_idle("t3", 40);
    chk("t3_pkts", 64'(log_port.size()), 64'(2));
    chk("t3_first", 64'(lp(0)), 64'(1));
    chk("t3_second", 64'(lp(1)), 64'(0));

    // Port 3 drops tvalid for 2 cycles mid-packet while port 0 requests.
    do_reset();
    push(3, 9, 4, 1, 2);
    n = 0;
    while (!grant_active && n < 20) begin
      tick();
      n++;
    end
    chk("t4_granted", 64'(n < 20), 64'(1));
    push(0, 3, 1, -1, 0);
    run_idle("t4", 40);
    chk("t4_pkts", 64'(log_port.size()), 64'(2));
    chk("t4_first", 64'(lp(0)), 64'(3));
    chk("t4_second", 64'(lp(1)), 64'(0));
    chk("t4_beats", 64'(beat_cnt), 64'(5));
    chk("t4_eop_spacing", 64'(lc(1) - lc(0)), 64'(2));

    // Reset pulsed during a port 2 packet.
    do_reset();
    push(2, 5, 4, -1, 0);
    n = 0;
    while (q[2].size() > 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_two_beats", 64'(n < 20), 64'(1));
    rst = 1'b1;
    flush();
    drive();
    #1;
    chk("t5_rst_tready", 64'(s_axis_tready), 64'(0));
    chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t5_rst_active", 64'(grant_active), 64'(0));
    tick();
    rst = 1'b0;
    clear_log();
    push(2, 4, 1, -1, 0);
    push(0, 6, 1, -1, 0);
    run_idle("t5", 40);
    chk("t5_pkts", 64'(log_port.size()), 64'(2));
    chk("t5_first", 64'(lp(0)), 64'(0));
    chk("t5_second", 64'(lp(1)), 64'(2));

`ifdef NF_TX_ARB_PKT_CNT_EN
    // Counter wrap, increment and clear coincident with tlast.
    do_reset();
    dut.cnt_q[1] = 32'hFFFF_FFFF;
    push(1, 20, 1, -1, 0);
    run_idle("t6a", 20);
    chk("t6_wrap", 64'(pkt_cnt[63:32]), 64'(0));
    push(1, 21, 1, -1, 0);
    run_idle("t6b", 20);
    chk("t6_incr", 64'(pkt_cnt[63:32]), 64'(1));
    push(1, 22, 1, -1, 0);
    n = 0;
    while (!grant_active && n < 20) begin
      tick();
      n++;
    end
    pkt_cnt_clear = 1'b1;
    tick();
    pkt_cnt_clear = 1'b0;
    chk("t6_clear_wins", 64'(pkt_cnt[63:32]), 64'(0));
    chk("t6_port0", 64'(pkt_cnt[31:0]), 64'(0));
    run_idle("t6c", 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
